// File: rtl/joy_adc_spi_reader.sv
// ============================================================================
//  Module      : joy_adc_spi_reader
//  Description : Free-running two-channel SPI ADC scanner for an analogue
//                joystick. Each scan converts channel 0 (X) then channel 1
//                (Y) and publishes both codes together with the switch level.
//                Optional macro JOY_ADC_DEADZONE_EN snaps codes within
//                DEADZONE of mid-scale (512) to exactly 512.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module joy_adc_spi_reader #(
    parameter int SCLK_DIV = 4,
    parameter int SCAN_GAP = 1000,
    parameter int DEADZONE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       adc_miso,
    input  logic       joy_sw,
    output logic       adc_cs_n,
    output logic       adc_sclk,
    output logic       adc_mosi,
    output logic [9:0] digital_x,
    output logic [9:0] digital_y,
    output logic       joy_button,
    output logic       sample_valid,
    output logic       busy
);

    localparam int HALF_W = $clog2(SCLK_DIV);
    localparam int GAP_W  = (SCAN_GAP > 1) ? $clog2(SCAN_GAP) : 1;

    localparam logic [HALF_W-1:0] C_HALF_LAST = HALF_W'(SCLK_DIV - 1);
    localparam logic [GAP_W-1:0]  C_GAP_LAST  = GAP_W'(SCAN_GAP - 1);
    localparam logic [3:0]        C_EDGE_LAST = 4'd15;
    localparam logic [3:0]        C_EDGE_DATA = 4'd6;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CS_SETUP = 3'd1,
        S_SHIFT    = 3'd2,
        S_CS_HOLD  = 3'd3,
        S_GAP      = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_next;

    logic [HALF_W-1:0]  r_half_cnt;
    logic               r_sclk_ph;      // 0 = low half, 1 = high half of SCLK
    logic [3:0]         r_edge_cnt;     // SCLK period index, 0..15
    logic [GAP_W-1:0]   r_gap_cnt;
    logic               r_ch;           // channel being converted
    logic [9:0]         r_shift;
    logic [9:0]         r_x_cap;
    logic [9:0]         r_x;
    logic [9:0]         r_y;
    logic               r_btn;
    logic               r_valid;

    logic               w_half_done;
    logic               w_gap_done;
    logic               w_cmd_bit;
    logic               w_cs_n;
    logic               w_sclk;
    logic               w_mosi;
    logic               w_busy;

    assign w_half_done = (r_half_cnt == C_HALF_LAST);
    assign w_gap_done  = (r_gap_cnt == C_GAP_LAST);

`ifdef JOY_ADC_DEADZONE_EN
    localparam int C_DZ_LO = 512 - DEADZONE;
    localparam int C_DZ_HI = 512 + DEADZONE;

    // Codes inside the centre window are snapped to mid-scale.
    function automatic logic [9:0] f_publish(input logic [9:0] c);
        int v;
        v = int'({22'd0, c});
        if (v >= C_DZ_LO && v <= C_DZ_HI) begin
            return 10'd512;
        end
        return c;
    endfunction
`else
    logic w_unused_dz;
    assign w_unused_dz = (DEADZONE != 0);

    // Without the dead zone the raw code is published.
    function automatic logic [9:0] f_publish(input logic [9:0] c);
        return c;
    endfunction
`endif

    // Command word 1,1,ch,1 for the first four SCLK periods, then zeros.
    always_comb begin
        w_cmd_bit = 1'b0;
        case (r_edge_cnt)
            4'd0:    w_cmd_bit = 1'b1;
            4'd1:    w_cmd_bit = 1'b1;
            4'd2:    w_cmd_bit = r_ch;
            4'd3:    w_cmd_bit = 1'b1;
            default: w_cmd_bit = 1'b0;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic and SPI pin decode.
    always_comb begin
        w_next = r_state;
        w_cs_n = 1'b1;
        w_sclk = 1'b0;
        w_mosi = 1'b0;
        w_busy = 1'b1;
        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (enable) begin
                    w_next = S_CS_SETUP;
                end
            end
            S_CS_SETUP: begin
                w_cs_n = 1'b0;
                if (w_half_done) begin
                    w_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                w_cs_n = 1'b0;
                w_sclk = r_sclk_ph;
                w_mosi = w_cmd_bit;
                if (w_half_done && r_sclk_ph && (r_edge_cnt == C_EDGE_LAST)) begin
                    w_next = S_CS_HOLD;
                end
            end
            S_CS_HOLD: begin
                if (w_half_done) begin
                    w_next = r_ch ? S_GAP : S_CS_SETUP;
                end
            end
            S_GAP: begin
                if (w_gap_done) begin
                    w_next = enable ? S_CS_SETUP : S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Half-period, SCLK phase, edge and gap counters; all restart on state entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_half_cnt <= '0;
            r_sclk_ph  <= 1'b0;
            r_edge_cnt <= 4'd0;
            r_gap_cnt  <= '0;
        end else if (r_state != w_next) begin
            r_half_cnt <= '0;
            r_sclk_ph  <= 1'b0;
            r_edge_cnt <= 4'd0;
            r_gap_cnt  <= '0;
        end else begin
            case (r_state)
                S_CS_SETUP, S_CS_HOLD: begin
                    r_half_cnt <= r_half_cnt + HALF_W'(1);
                end
                S_SHIFT: begin
                    if (w_half_done) begin
                        r_half_cnt <= '0;
                        r_sclk_ph  <= ~r_sclk_ph;
                        if (r_sclk_ph) begin
                            r_edge_cnt <= r_edge_cnt + 4'd1;
                        end
                    end else begin
                        r_half_cnt <= r_half_cnt + HALF_W'(1);
                    end
                end
                S_GAP: begin
                    r_gap_cnt <= r_gap_cnt + GAP_W'(1);
                end
                default: begin
                    r_half_cnt <= '0;
                end
            endcase
        end
    end

    // Data capture on SCLK rising edges 7..16, channel sequencing and publish.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ch    <= 1'b0;
            r_shift <= 10'd0;
            r_x_cap <= 10'd0;
            r_x     <= 10'd0;
            r_y     <= 10'd0;
            r_btn   <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            // MISO is taken on the clk edge that raises SCLK.
            if ((r_state == S_SHIFT) && w_half_done && !r_sclk_ph &&
                (r_edge_cnt >= C_EDGE_DATA)) begin
                r_shift <= {r_shift[8:0], adc_miso};
            end
            if ((r_state == S_CS_HOLD) && w_half_done) begin
                if (!r_ch) begin
                    r_x_cap <= r_shift;
                    r_ch    <= 1'b1;
                end else begin
                    r_x     <= f_publish(r_x_cap);
                    r_y     <= f_publish(r_shift);
                    r_btn   <= joy_sw;
                    r_valid <= 1'b1;
                    r_ch    <= 1'b0;
                end
            end
        end
    end

    assign adc_cs_n     = w_cs_n;
    assign adc_sclk     = w_sclk;
    assign adc_mosi     = w_mosi;
    assign busy         = w_busy;
    assign digital_x    = r_x;
    assign digital_y    = r_y;
    assign joy_button   = r_btn;
    assign sample_valid = r_valid;

endmodule

`default_nettype wire

// File: tb/tb_joy_adc_spi_reader.sv
// ============================================================================
//  Module      : tb_joy_adc_spi_reader
//  Description : Self-checking bench for joy_adc_spi_reader: ADC model on
//                the SPI pins, SPI protocol monitor, timeline model of the
//                scan schedule, and directed scenarios.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_joy_adc_spi_reader;

    localparam int SCLK_DIV = 4;
    localparam int SCAN_GAP = 20;
    localparam int DZ       = 16;
    localparam int CONV_LEN = 34 * SCLK_DIV;
    localparam int SCAN_LEN = 2 * (SCLK_DIV + 32 * SCLK_DIV + SCLK_DIV);
    localparam int M_IDLE   = 0;
    localparam int M_SCAN   = 1;
    localparam int M_GAP    = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic       adc_miso;
    logic       joy_sw = 1'b0;
    logic       adc_cs_n;
    logic       adc_sclk;
    logic       adc_mosi;
    logic [9:0] digital_x;
    logic [9:0] digital_y;
    logic       joy_button;
    logic       sample_valid;
    logic       busy;

    int errors = 0;
    int checks = 0;
    logic cmp_en = 1'b0;

    logic [9:0] x_code = 10'd0;
    logic [9:0] y_code = 10'd0;

    joy_adc_spi_reader #(
        .SCLK_DIV (SCLK_DIV),
        .SCAN_GAP (SCAN_GAP),
        .DEADZONE (DZ)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .adc_miso     (adc_miso),
        .joy_sw       (joy_sw),
        .adc_cs_n     (adc_cs_n),
        .adc_sclk     (adc_sclk),
        .adc_mosi     (adc_mosi),
        .digital_x    (digital_x),
        .digital_y    (digital_y),
        .joy_button   (joy_button),
        .sample_valid (sample_valid),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Published value of a captured code.
    function automatic logic [9:0] f_pub(input logic [9:0] c);
`ifdef JOY_ADC_DEADZONE_EN
        if (int'({22'd0, c}) >= 512 - DZ && int'({22'd0, c}) <= 512 + DZ) return 10'd512;
`endif
        return c;
    endfunction

    // ---------------- SPI monitor and ADC model ----------------
    int         mon_rise = 0;
    logic [3:0] mon_cmd  = 4'd0;
    logic       mon_win  = 1'b0;
    logic       p_cs_n = 1'b1, p_sclk = 1'b0, p_mosi = 1'b0;
    logic [9:0] w_code;

    assign w_code = mon_cmd[1] ? y_code : x_code;

    // ADC drives B9..B0 ahead of rising edges 7..16.
    always_comb begin
        adc_miso = 1'b0;
        if (mon_rise >= 6 && mon_rise <= 15) adc_miso = w_code[4'(15 - mon_rise)];
    end

    always @(negedge clk) begin
        if (rst) begin
            mon_rise = 0;
            mon_cmd  = 4'd0;
            mon_win  = 1'b0;
        end else begin
            if (!adc_cs_n && p_cs_n) begin
                mon_rise = 0;
                mon_cmd  = 4'd0;
            end
            if (adc_sclk && !p_sclk) begin
                if (mon_rise < 4) mon_cmd = {mon_cmd[2:0], adc_mosi};
                mon_rise++;
            end
            if (adc_sclk && p_sclk) chk("mosi_stable_sclk_high", adc_mosi, p_mosi);
            if (adc_cs_n && !p_cs_n) begin
                chk("rising_edges_per_window", mon_rise, 16);
                chk("cmd_bits", mon_cmd, {2'b11, mon_win, 1'b1});
                mon_win = ~mon_win;
            end
        end
        p_cs_n = adc_cs_n;
        p_sclk = adc_sclk;
        p_mosi = adc_mosi;
    end

    // ---------------- timeline model ----------------
    int         m_phase = M_IDLE;
    int         m_t = 0;
    logic       m_valid = 1'b0;
    logic [9:0] m_x = 10'd0, m_y = 10'd0;
    logic       m_btn = 1'b0;

    always @(posedge clk) begin
        m_valid = 1'b0;
        if (rst) begin
            m_phase = M_IDLE; m_t = 0;
            m_x = 10'd0; m_y = 10'd0; m_btn = 1'b0;
        end else begin
            case (m_phase)
                M_IDLE: if (enable) begin m_phase = M_SCAN; m_t = 0; end
                M_SCAN: begin
                    m_t++;
                    if (m_t == SCAN_LEN) begin
                        m_phase = M_GAP; m_t = 0; m_valid = 1'b1;
                        m_x = f_pub(x_code); m_y = f_pub(y_code); m_btn = joy_sw;
                    end
                end
                default: begin
                    m_t++;
                    if (m_t == SCAN_GAP) begin
                        m_phase = enable ? M_SCAN : M_IDLE;
                        m_t = 0;
                    end
                end
            endcase
        end
    end

    // Cycle-by-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            int   o;
            logic e_cs_n, e_sclk;
            e_cs_n = 1'b1; e_sclk = 1'b0;
            if (m_phase == M_SCAN) begin
                o = m_t % CONV_LEN;
                if (o < 33 * SCLK_DIV) e_cs_n = 1'b0;
                if (o >= SCLK_DIV && o < 33 * SCLK_DIV)
                    e_sclk = (((o - SCLK_DIV) / SCLK_DIV) % 2) == 1;
            end
            chk("cmp_busy", busy, m_phase != M_IDLE);
            chk("cmp_sample_valid", sample_valid, m_valid);
            chk("cmp_digital_x", digital_x, m_x);
            chk("cmp_digital_y", digital_y, m_y);
            chk("cmp_joy_button", joy_button, m_btn);
            chk("cmp_adc_cs_n", adc_cs_n, e_cs_n);
            chk("cmp_adc_sclk", adc_sclk, e_sclk);
        end
    end

    // Wait for a sample_valid pulse with a cycle budget.
    task automatic wait_valid(input string name, input int budget, output int n);
        n = 0;
        while (sample_valid !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        if (sample_valid !== 1'b1) begin
            checks++; errors++;
            $display("FAIL %s: got no sample_valid required pulse within %0d cycles", name, budget);
        end
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        int n;
        int cnt_cs, cnt_v;
        logic [9:0] dz_x, dz_y;

        rst = 1'b1;
        tick();
        cmp_en = 1'b1;
        tick();
        tick();
        chk("reset_cs_n", adc_cs_n, 1);
        chk("reset_sclk", adc_sclk, 0);
        chk("reset_mosi", adc_mosi, 0);
        chk("reset_x", digital_x, 0);
        chk("reset_y", digital_y, 0);
        chk("reset_btn", joy_button, 0);
        chk("reset_valid", sample_valid, 0);
        chk("reset_busy", busy, 0);

        // Nominal scan and latency.
        x_code = 10'h2A5; y_code = 10'h13C; joy_sw = 1'b1;
        rst = 1'b0; enable = 1'b1;
        tick();
        chk("busy_after_start", busy, 1);
        wait_valid("scan1", 400, n);
        chk("scan1_latency", n, 272);
        chk("scan1_x", digital_x, 10'h2A5);
        chk("scan1_y", digital_y, 10'h13C);
        chk("scan1_btn", joy_button, 1);
        x_code = 10'h3FF; y_code = 10'h000; joy_sw = 1'b0;
        tick();
        chk("valid_one_cycle", sample_valid, 0);
        chk("hold_x", digital_x, 10'h2A5);

        // Full-scale codes.
        wait_valid("scan2", 400, n);
        chk("fullscale_x", digital_x, 10'h3FF);
        chk("fullscale_y", digital_y, 10'h000);
        chk("scan2_btn", joy_button, 0);

        // Dead-zone codes.
        x_code = 10'h20A; y_code = 10'h1E0; joy_sw = 1'b1;
        tick();
`ifdef JOY_ADC_DEADZONE_EN
        dz_x = 10'd512;
`else
        dz_x = 10'h20A;
`endif
        wait_valid("scan3", 400, n);
        chk("dz_x_522", digital_x, dz_x);
        chk("dz_y_480", digital_y, 10'h1E0);

        // Dead-zone boundaries 496 and 528.
        x_code = 10'h1F0; y_code = 10'h210;
        tick();
`ifdef JOY_ADC_DEADZONE_EN
        dz_x = 10'd512; dz_y = 10'd512;
`else
        dz_x = 10'h1F0; dz_y = 10'h210;
`endif
        wait_valid("scan4", 400, n);
        chk("dz_x_496", digital_x, dz_x);
        chk("dz_y_528", digital_y, dz_y);

        // Enable dropped during the X conversion.
        x_code = 10'h155; y_code = 10'h2AA;
        n = 0;
        while (adc_cs_n !== 1'b0 && n < 100) begin tick(); n++; end
        chk("scan5_started", adc_cs_n, 0);
        repeat (20) tick();
        enable = 1'b0;
        wait_valid("scan5", 400, n);
        chk("late_disable_x", digital_x, 10'h155);
        chk("late_disable_y", digital_y, 10'h2AA);
        n = 0;
        while (busy !== 1'b0 && n < SCAN_GAP + 5) begin tick(); n++; end
        chk("idle_after_gap", busy, 0);
        cnt_cs = 0; cnt_v = 0;
        repeat (300) begin
            tick();
            if (adc_cs_n == 1'b0) cnt_cs++;
            if (sample_valid == 1'b1) cnt_v++;
        end
        chk("no_cs_activity_when_idle", cnt_cs, 0);
        chk("no_valid_when_idle", cnt_v, 0);

        // Reset at SCLK edge 10 of the Y conversion.
        x_code = 10'h0F0; y_code = 10'h30F; enable = 1'b1;
        n = 0;
        while (!(mon_win == 1'b1 && mon_rise == 10) && n < 400) begin tick(); n++; end
        chk("reached_y_edge10", mon_rise, 10);
        rst = 1'b1; enable = 1'b0;
        tick();
        chk("abort_cs_n", adc_cs_n, 1);
        chk("abort_x", digital_x, 0);
        chk("abort_y", digital_y, 0);
        chk("abort_btn", joy_button, 0);
        chk("abort_valid", sample_valid, 0);
        chk("abort_busy", busy, 0);
        rst = 1'b0;
        cnt_v = 0;
        repeat (300) begin
            tick();
            if (sample_valid == 1'b1) cnt_v++;
        end
        chk("no_valid_after_abort", cnt_v, 0);

        // Recovery scan after the abort.
        x_code = 10'h2A5; y_code = 10'h13C; joy_sw = 1'b1; enable = 1'b1;
        wait_valid("scan6", 400, n);
        chk("recover_x", digital_x, 10'h2A5);
        chk("recover_y", digital_y, 10'h13C);
        enable = 1'b0;
        repeat (SCAN_GAP + 10) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/joy_adc_spi_reader.md
JOY_ADC_SPI_READER -- requirements
Module: joy_adc_spi_reader

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter SCLK_DIV, default 4, SHALL set the clk cycles per SCLK half-period; legal values are 2 or more.
REQ-003 Parameter SCAN_GAP, default 1000, SHALL set the idle clk cycles between the end of one scan and the start of the next.
REQ-004 Parameter DEADZONE, default 16, SHALL set the half-width of the centre dead zone in ADC codes.
REQ-005 clk  input  1  system clock.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 enable  input  1  free-run scanning while high.
REQ-008 adc_miso  input  1  serial data from the ADC.
REQ-009 joy_sw  input  1  joystick switch level, already synchronised.
REQ-010 adc_cs_n  output  1  ADC chip select, active low.
REQ-011 adc_sclk  output  1  SPI clock, idle low.
REQ-012 adc_mosi  output  1  command bits to the ADC.
REQ-013 digital_x  output  10  last X code (channel 0).
REQ-014 digital_y  output  10  last Y code (channel 1).
REQ-015 joy_button  output  1  joy_sw sampled at scan completion.
REQ-016 sample_valid  output  1  one-cycle pulse when the outputs update.
REQ-017 busy  output  1  high whenever the state is not IDLE.

Function
REQ-018 The FSM SHALL use the states IDLE, CS_SETUP, SHIFT, CS_HOLD and GAP.
REQ-019 IDLE SHALL go to CS_SETUP when enable=1.
REQ-020 CS_SETUP SHALL drive adc_cs_n=0 for SCLK_DIV cycles and then go to SHIFT.
REQ-021 SHIFT SHALL generate exactly 16 SCLK periods, each SCLK_DIV cycles low followed by SCLK_DIV cycles high.
REQ-022 adc_mosi SHALL present the command bits 1, 1, ch, 1 before rising edges 1 to 4, and 0 thereafter.
REQ-023 adc_mosi SHALL change only while adc_sclk is low.
REQ-024 adc_miso SHALL be sampled in the clk cycle in which adc_sclk rises.
REQ-025 Rising edges 7 to 16 SHALL capture data bits B9 to B0, MSB first; edges 1 to 6 are discarded.
REQ-026 After edge 16 and its high half-period, the FSM SHALL go to CS_HOLD, driving adc_cs_n=1 and adc_sclk=0 for SCLK_DIV cycles.
REQ-027 One scan SHALL consist of conversion ch=0 (X) followed by conversion ch=1 (Y).
REQ-028 After the ch=0 conversion, CS_HOLD SHALL return to CS_SETUP with ch=1.
REQ-029 After the ch=1 conversion, CS_HOLD SHALL go to GAP.
REQ-030 On the CS_HOLD-to-GAP transition, digital_x, digital_y and joy_button SHALL update together, and sample_valid SHALL pulse for exactly 1 cycle.
REQ-031 Partial scans SHALL never update the outputs.
REQ-032 GAP SHALL last SCAN_GAP cycles.
REQ-033 At the end of GAP, the FSM SHALL go to CS_SETUP with ch=0 if enable=1, otherwise to IDLE.
REQ-034 Deasserting enable mid-scan SHALL let the current scan complete and publish its results, then go to IDLE.
REQ-035 Scan latency from leaving IDLE to sample_valid SHALL be 2*(SCLK_DIV + 32*SCLK_DIV + SCLK_DIV) cycles, which is 272 cycles at the default.
REQ-036 The half-period and gap counters SHALL be sized from the parameters and SHALL wrap to 0 on each state entry.
REQ-037 Outputs SHALL hold their values between sample_valid pulses.

Reset
REQ-038 While rst=1, the FSM SHALL go to IDLE on the next clk edge.
REQ-039 The reset values SHALL be: adc_cs_n=1, adc_sclk=0, adc_mosi=0, digital_x=0, digital_y=0, joy_button=0, sample_valid=0, busy=0, ch=0, and all counters 0.
REQ-040 A reset asserted mid-SHIFT SHALL abort the conversion with no output update, and adc_cs_n SHALL be 1 on the next clk edge.

Configuration
REQ-041 With JOY_ADC_DEADZONE_EN defined, each captured code c with 512-DEADZONE <= c <= 512+DEADZONE SHALL be published as 512; codes outside that range SHALL pass unchanged.
REQ-042 Without JOY_ADC_DEADZONE_EN, captured codes SHALL be published unmodified, and the DEADZONE parameter SHALL be ignored.

Verification
REQ-043 ADC model returns X=0x2A5 and Y=0x13C, with enable=1 and joy_sw=1 -> after 272 cycles, sample_valid pulses once with digital_x=0x2A5, digital_y=0x13C and joy_button=1.
REQ-044 A bench monitor checks the MOSI bits sampled at rising edges 1 to 4 -> they read 1101 for X and 1111 for Y; it also checks exactly 16 SCLK rising edges per cs_n-low window and adc_mosi stable while adc_sclk is high.
REQ-045 rst pulsed at SCLK edge 10 of the Y conversion -> adc_cs_n=1 the next cycle, all outputs 0, and no sample_valid pulse.
REQ-046 enable dropped during the X conversion -> that scan still publishes, then busy=0 after the gap and no further cs_n activity.
REQ-047 JOY_ADC_DEADZONE_EN defined, with model codes 0x20A (522) and 0x1E0 (480) -> digital_x=512 and digital_y=480.
REQ-048 Model returns X=0x3FF and Y=0x000 -> full-scale codes are published exactly, with no truncation or sign error.
